// File: rtl/regfile_scoreboard.sv
// Register file with a per-register busy scoreboard: it issues an instruction only when
// its operands are ready, bypasses writeback data to the operands and flags stray writebacks.
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  input  logic [AW-1:0]   iss_rd,
  input  logic            iss_wr,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic [AW:0]     busy_count,
  output logic            wb_err
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [NREGS-1:0] clr_mask;
  logic [NREGS-1:0] set_mask;
  logic             rd_zero, wb_zero, rs1_zero, rs2_zero;
  logic             byp1, byp2, byp_rd, haz1, haz2, haz_rd, accept, wb_live;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == {AW{1'b0}});
  endfunction

  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] c;
    c = {(AW+1){1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Hazard detection, issue handshake and next-state busy vector
  always_comb begin
    rd_zero   = is_zero(iss_rd);
    wb_zero   = is_zero(wb_rd);
    rs1_zero  = is_zero(iss_rs1);
    rs2_zero  = is_zero(iss_rs2);
    wb_live   = wb_en && !wb_zero;
    byp1      = wb_en && (wb_rd == iss_rs1);
    byp2      = wb_en && (wb_rd == iss_rs2);
    byp_rd    = wb_en && (wb_rd == iss_rd);
    haz1      = busy[iss_rs1] && !byp1;
    haz2      = busy[iss_rs2] && !byp2;
    haz_rd    = iss_wr && !rd_zero && busy[iss_rd] && !byp_rd;
    iss_ready = !flush && !haz1 && !haz2 && !haz_rd;
    accept    = iss_valid && iss_ready;
    clr_mask  = wb_live ? ({{(NREGS-1){1'b0}}, 1'b1} << wb_rd) : {NREGS{1'b0}};
    set_mask  = (accept && iss_wr && !rd_zero) ? ({{(NREGS-1){1'b0}}, 1'b1} << iss_rd)
                                               : {NREGS{1'b0}};
    // A new reservation wins over a same-cycle writeback to the same register
    busy_nxt  = ((flush ? {NREGS{1'b0}} : busy) & ~clr_mask) | set_mask;
  end

  // Operand read ports with writeback bypass
  always_comb begin
    if (rs1_zero) begin
      rdata1 = {XLEN{1'b0}};
    end else if (byp1) begin
      rdata1 = wb_data;
    end else begin
      rdata1 = regs[iss_rs1];
    end
    if (rs2_zero) begin
      rdata2 = {XLEN{1'b0}};
    end else if (byp2) begin
      rdata2 = wb_data;
    end else begin
      rdata2 = regs[iss_rs2];
    end
  end

  // Register data storage
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= {XLEN{1'b0}};
      end
    end else if (wb_live) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Busy vector, its population count and the sticky writeback error
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy       <= {NREGS{1'b0}};
      busy_count <= {(AW+1){1'b0}};
      wb_err     <= 1'b0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= popcount(busy_nxt);
      if (wb_live && !busy[wb_rd]) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning register count (power of 2, >= 2); AW = log2(NREGS).
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning 1 = register 0 hardwired to zero and never busy.
REQ-004 SHALL have ports: clk input 1, rising-edge clock; rst input 1, reset, synchronous and active-low.
REQ-005 SHALL have ports: iss_valid input 1, issue request; iss_ready output 1, issue accepted when both high.
REQ-006 SHALL have ports: iss_rs1, iss_rs2, iss_rd inputs AW each; iss_wr input 1, meaning the instruction writes rd.
REQ-007 SHALL have ports: rdata1, rdata2 outputs XLEN each, operand values for iss_rs1 and iss_rs2.
REQ-008 SHALL have ports: wb_en input 1, wb_rd input AW, wb_data input XLEN, writeback.
REQ-009 SHALL have ports: flush input 1, clears all pending reservations.
REQ-010 SHALL have ports: busy_count output AW+1, number of busy registers; wb_err output 1, sticky error flag.

Function
REQ-011 SHALL hold NREGS x XLEN data registers and an NREGS-bit busy vector, all updated only on rising clk.
REQ-012 SHALL drive rdata1/rdata2 combinationally: wb_data when wb_en and wb_rd equals the source (bypass); otherwise the stored value; 0 for register 0 when ZERO_REG=1.
REQ-013 SHALL treat a source as hazarded when its busy bit is 1 and it is not bypassed in the same cycle.
REQ-014 SHALL drive iss_ready = !flush && no hazard on rs1 && no hazard on rs2 && !(iss_wr && busy[iss_rd] && !(wb_en && wb_rd==iss_rd)).
REQ-015 SHALL ignore the rd term of iss_ready, and all busy marking, when iss_rd is 0 and ZERO_REG=1.
REQ-016 SHALL, on issue accept (iss_valid && iss_ready) with iss_wr, set busy[iss_rd] at the next edge.
REQ-017 SHALL, on wb_en, write wb_data into wb_rd and clear busy[wb_rd] at the next edge; writes to register 0 SHALL be dropped when ZERO_REG=1.
REQ-018 SHALL resolve same-cycle writeback and accepted issue to the same rd as: data written, busy ends 1 (the new reservation wins).
REQ-019 SHALL set wb_err at the next edge when wb_en targets a register whose busy bit is 0 (excluding register 0 with ZERO_REG=1); the data SHALL still be written.
REQ-020 SHALL hold wb_err at 1 until reset.
REQ-021 SHALL, on flush, clear every busy bit at the next edge; register data SHALL be unaffected; a same-cycle wb_en write SHALL still occur.
REQ-022 SHALL make iss_ready 0 during flush, so no reservation is made in that cycle.
REQ-023 SHALL keep busy_count equal to the population count of the busy vector after each edge (registered, no lag versus busy).
REQ-024 SHALL handle iss_valid low as no reservation, with iss_ready still computed from the inputs.

Reset
REQ-025 SHALL, when rst is 0 at a rising edge, clear all data registers to 0, all busy bits to 0, busy_count to 0 and wb_err to 0.
REQ-026 SHALL give reset priority over flush, issue and writeback in the same cycle; a reset mid-operation discards all reservations.
REQ-027 SHALL present, after reset and with iss_valid low, iss_ready 1, rdata1 = rdata2 = 0 for any address.

Verification
REQ-028 SHALL pass: issue rd=5 (iss_wr=1) -> next cycle busy_count=1; issue with rs1=5 -> iss_ready=0; wb_en rd=5 data=0xDEADBEEF -> same cycle rdata1=0xDEADBEEF, iss_ready=1.
REQ-029 SHALL pass: write 0x12345678 to x0 with ZERO_REG=1 -> rdata1 for rs1=0 reads 0, wb_err stays 0, busy_count stays 0.
REQ-030 SHALL pass: rd=7 busy, same cycle issue rd=7 plus wb_en rd=7 data=0xA5 -> iss_ready=1; next cycle reg7=0xA5, busy[7]=1, busy_count=1.
REQ-031 SHALL pass: reserve x1, x2, x3 (busy_count=3), assert flush with iss_valid=1 -> iss_ready=0; next cycle busy_count=0 and data unchanged.
REQ-032 SHALL pass: wb_en rd=9 while x9 not busy -> next cycle wb_err=1, reg9 updated; wb_err stays 1 until rst=0.
REQ-033 SHALL pass: with NREGS=16, XLEN=64, fill all 15 non-zero registers busy -> busy_count=15; rst=0 in the same cycle as a writeback -> next cycle all zero, wb_err=0.
